// File: rtl/iob_mem_subordinate_responder_if.sv
// IOb request/response bundle between a manager and a subordinate.
// The manager drives the request fields and the subordinate drives ready and the read response.
interface iob_mem_subordinate_responder_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              iob_valid;
    logic [ADDR_W-1:0] iob_addr;
    logic [DATA_W-1:0] iob_wdata;
    logic [STRB_W-1:0] iob_wstrb;
    logic              iob_rvalid;
    logic [DATA_W-1:0] iob_rdata;
    logic              iob_ready;

    modport master (
        output iob_valid, iob_addr, iob_wdata, iob_wstrb,
        input  iob_rvalid, iob_rdata, iob_ready
    );

    modport slave (
        input  iob_valid, iob_addr, iob_wdata, iob_wstrb,
        output iob_rvalid, iob_rdata, iob_ready
    );
endinterface

// File: rtl/iob_mem_subordinate_responder.sv
// IOb subordinate backed by a word-addressed memory.
// It inserts programmable wait states, performs byte-strobed writes and returns registered read data.
module iob_mem_subordinate_responder #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned WAIT_CYC = 0
) (
    input  logic                             clk_i,
    input  logic                             cke_i,
    input  logic                             rst_i,
    iob_mem_subordinate_responder_if.slave   iob
);
    localparam int unsigned STRB_W  = DATA_W / 8;
    localparam int unsigned WORD_AW = ADDR_W - 2;
    localparam int unsigned DEPTH   = 1 << WORD_AW;
    localparam int unsigned CNT_W   = 4;

    localparam logic [CNT_W-1:0] CNT_INIT   = (WAIT_CYC == 0) ? '0 : CNT_W'(WAIT_CYC - 1);
    localparam logic             READY_IDLE = (WAIT_CYC == 0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_q, ready_d;
    logic               rvalid_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               accept_c;
    logic               is_read_c;
    logic               wr_en_c;
    logic               rd_en_c;
    logic [WORD_AW-1:0] word_idx_c;
    logic               unused_addr_lsb;

    logic [DATA_W-1:0]  mem [DEPTH];

    assign word_idx_c      = iob.iob_addr[ADDR_W-1:2];
    assign unused_addr_lsb = ^iob.iob_addr[1:0];

    // Next state, wait counter and the ready value the next state will present
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept_c  = 1'b0;
        ready_d   = 1'b0;
        is_read_c = (iob.iob_wstrb == '0);

        case (state_q)
            ST_IDLE: begin
                if (iob.iob_valid) begin
                    if (WAIT_CYC != 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        accept_c = 1'b1;
                        if (is_read_c) begin
                            state_d = ST_RESP;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (!iob.iob_valid) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    accept_c = 1'b1;
                    state_d  = is_read_c ? ST_RESP : ST_IDLE;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case (state_d)
            ST_IDLE: ready_d = READY_IDLE;
            ST_WAIT: ready_d = (cnt_d == '0);
            default: ready_d = 1'b0;
        endcase

        wr_en_c = accept_c & ~is_read_c;
        rd_en_c = accept_c & is_read_c;
    end

    // FSM state register; ready is registered so it depends on state only
    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (rst_i) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                ready_q <= READY_IDLE;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                ready_q <= ready_d;
            end
        end
    end

    // Read response; reset cancels a read accepted in the same cycle
    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (rst_i) begin
                rvalid_q <= 1'b0;
                rdata_q  <= '0;
            end else begin
                rvalid_q <= rd_en_c;
                if (rd_en_c) begin
                    rdata_q <= mem[word_idx_c];
                end
            end
        end
    end

    // Byte-strobed memory write; contents survive reset
    always_ff @(posedge clk_i) begin
        if (cke_i && !rst_i && wr_en_c) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (iob.iob_wstrb[k]) begin
                    mem[word_idx_c][k*8 +: 8] <= iob.iob_wdata[k*8 +: 8];
                end
            end
        end
    end

    assign iob.iob_ready  = ready_q;
    assign iob.iob_rvalid = rvalid_q;
    assign iob.iob_rdata  = rdata_q;
endmodule
